// File: rtl/pep_ks_common_definition_pkg.sv
// Tile geometry shared by the keyswitch datapath and its sequencers.
package pep_ks_common_definition_pkg;
    localparam int LBX = 3;
    localparam int LBY = 64;
    localparam int LBZ = 3;
endpackage

// File: rtl/pep_ks_tile_seq_pkg.sv
// Types and constants for the keyswitch tile sequencer.
package pep_ks_tile_seq_pkg;
    import pep_ks_common_definition_pkg::*;

    localparam int KS_LWE_K_W  = 12;
    localparam int KS_BLWE_K_W = 14;
    localparam int KS_LEVEL_W  = 5;

    // LOAD always lasts exactly this many cycles, independent of LBX/LBY/LBZ,
    // so the first tile is valid two cycles after command acceptance.
    localparam int LOAD_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [KS_LWE_K_W-1:0]      x;
        logic [KS_BLWE_K_W-1:0]     y;
        logic [KS_LEVEL_W-1:0]      z;
        logic [LBX-1:0]             x_mask;
        logic [$clog2(LBY+1)-1:0]   y_nb;
        logic [$clog2(LBZ+1)-1:0]   z_nb;
        logic                       first;
        logic                       last;
        logic                       y_last;
    } tile_desc_t;
endpackage

// File: rtl/pep_ks_tile_cnt.sv
// Wrapping tile counter: tracks the remaining element count instead of dividing,
// so the last flag and the partial-group size fall out of a subtract-compare.
module pep_ks_tile_cnt #(
    parameter int W    = 12,
    parameter int LB   = 3,
    parameter int NB_W = $clog2(LB+1)
) (
    input  logic            clk,
    input  logic            s_rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [W-1:0]    total,
    output logic [W-1:0]    idx,
    output logic            last,
    output logic            last_nxt,
    output logic [NB_W-1:0] nb_nxt
);
    localparam logic [W:0] LB_V = (W+1)'(LB);

    logic [W-1:0] idx_q, idx_d;
    logic [W:0]   rem_q, rem_d;
    logic         last_q;

    always_comb begin
        idx_d = idx_q;
        rem_d = rem_q;
        if (load || (step && last_q)) begin
            idx_d = '0;
            rem_d = {1'b0, total};
        end else if (step) begin
            idx_d = idx_q + 1'b1;
            rem_d = rem_q - LB_V;
        end
        last_nxt = (rem_d <= LB_V);
        nb_nxt   = last_nxt ? NB_W'(rem_d) : NB_W'(LB);
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            idx_q  <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            rem_q  <= rem_d;
            last_q <= last_nxt;
        end
    end

    assign idx  = idx_q;
    assign last = last_q;
endmodule

// File: rtl/pep_ks_tile_seq.sv
// Keyswitch tile sequencer: walks (x, y, z) tiles of one command, z innermost.
//   state | meaning
//   IDLE  | ready for a command
//   LOAD  | command latched, counters loaded (one cycle)
//   RUN   | issuing tile descriptors
//   DONE  | one-cycle done pulse
module pep_ks_tile_seq
    import pep_ks_tile_seq_pkg::*;
#(
    parameter int LBX      = pep_ks_common_definition_pkg::LBX,
    parameter int LBY      = pep_ks_common_definition_pkg::LBY,
    parameter int LBZ      = pep_ks_common_definition_pkg::LBZ,
    parameter int LWE_K_W  = 12,
    parameter int BLWE_K_W = 14,
    parameter int LEVEL_W  = 5
) (
    input  logic                      clk,
    input  logic                      s_rst_n,
    input  logic                      cmd_vld,
    output logic                      cmd_rdy,
    input  logic [LWE_K_W-1:0]        cmd_lwe_k,
    input  logic [BLWE_K_W-1:0]       cmd_blwe_k,
    input  logic [LEVEL_W-1:0]        cmd_level,
    output logic                      tile_vld,
    input  logic                      tile_rdy,
    output logic [LWE_K_W-1:0]        tile_x,
    output logic [BLWE_K_W-1:0]       tile_y,
    output logic [LEVEL_W-1:0]        tile_z,
    output logic [LBX-1:0]            tile_x_mask,
    output logic [$clog2(LBY+1)-1:0]  tile_y_nb,
    output logic [$clog2(LBZ+1)-1:0]  tile_z_nb,
    output logic                      tile_first,
    output logic                      tile_last,
    output logic                      tile_y_last,
    output logic                      done
);
    localparam int XNB_W = $clog2(LBX+1);
    localparam int YNB_W = $clog2(LBY+1);
    localparam int ZNB_W = $clog2(LBZ+1);

    state_e                state_q, state_d;
    logic [LWE_K_W-1:0]    lwe_k_q, lwe_k_d;
    logic [BLWE_K_W-1:0]   blwe_k_q, blwe_k_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic                  cmd_rdy_q, cmd_rdy_d;
    logic                  tile_vld_q, tile_vld_d;
    logic                  done_q, done_d;
    logic                  tile_first_q, tile_first_d;
    logic                  tile_last_q, tile_last_d;
    logic                  tile_y_last_q, tile_y_last_d;
    logic [LBX-1:0]        tile_x_mask_q, tile_x_mask_d;
    logic [YNB_W-1:0]      tile_y_nb_q, tile_y_nb_d;
    logic [ZNB_W-1:0]      tile_z_nb_q, tile_z_nb_d;

    logic                  hs, cnt_load, x_step, y_step, z_step;
    logic                  x_last, y_last, z_last;
    logic                  x_last_nxt, y_last_nxt, z_last_nxt;
    logic [XNB_W-1:0]      x_nb_nxt;
    logic [YNB_W-1:0]      y_nb_nxt;
    logic [ZNB_W-1:0]      z_nb_nxt;
    logic                  cmd_empty;

    assign hs        = tile_vld_q && tile_rdy;
    assign cnt_load  = (state_q == ST_LOAD);
    assign z_step    = hs;
    assign y_step    = hs && z_last;
    assign x_step    = y_step && y_last;
    assign cmd_empty = (lwe_k_q == '0) || (blwe_k_q == '0) || (level_q == '0);

    pep_ks_tile_cnt #(.W(LWE_K_W), .LB(LBX), .NB_W(XNB_W)) u_cnt_x (
        .clk(clk), .s_rst_n(s_rst_n), .load(cnt_load), .step(x_step),
        .total(lwe_k_q), .idx(tile_x), .last(x_last),
        .last_nxt(x_last_nxt), .nb_nxt(x_nb_nxt)
    );

    pep_ks_tile_cnt #(.W(BLWE_K_W), .LB(LBY), .NB_W(YNB_W)) u_cnt_y (
        .clk(clk), .s_rst_n(s_rst_n), .load(cnt_load), .step(y_step),
        .total(blwe_k_q), .idx(tile_y), .last(y_last),
        .last_nxt(y_last_nxt), .nb_nxt(y_nb_nxt)
    );

    pep_ks_tile_cnt #(.W(LEVEL_W), .LB(LBZ), .NB_W(ZNB_W)) u_cnt_z (
        .clk(clk), .s_rst_n(s_rst_n), .load(cnt_load), .step(z_step),
        .total(level_q), .idx(tile_z), .last(z_last),
        .last_nxt(z_last_nxt), .nb_nxt(z_nb_nxt)
    );

    always_comb begin
        state_d  = state_q;
        lwe_k_d  = lwe_k_q;
        blwe_k_d = blwe_k_q;
        level_d  = level_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_vld && cmd_rdy_q) begin
                    lwe_k_d  = cmd_lwe_k;
                    blwe_k_d = cmd_blwe_k;
                    level_d  = cmd_level;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: state_d = cmd_empty ? ST_DONE : ST_RUN;
            ST_RUN:  if (hs && x_last && y_last && z_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cmd_rdy_d  = (state_d == ST_IDLE);
        tile_vld_d = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);

        // Descriptor flags are computed from the counters' next values so they stay registered.
        tile_first_d  = tile_vld_d && (cnt_load || (tile_first_q && !hs));
        tile_last_d   = tile_vld_d && x_last_nxt && y_last_nxt && z_last_nxt;
        tile_y_last_d = tile_vld_d && y_last_nxt && z_last_nxt;
        tile_y_nb_d   = y_nb_nxt;
        tile_z_nb_d   = z_nb_nxt;
        tile_x_mask_d = '0;
        for (int i = 0; i < LBX; i++) begin
            tile_x_mask_d[i] = tile_vld_d && (i < int'(x_nb_nxt));
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q       <= ST_IDLE;
            lwe_k_q       <= '0;
            blwe_k_q      <= '0;
            level_q       <= '0;
            cmd_rdy_q     <= 1'b1;
            tile_vld_q    <= 1'b0;
            done_q        <= 1'b0;
            tile_first_q  <= 1'b0;
            tile_last_q   <= 1'b0;
            tile_y_last_q <= 1'b0;
            tile_x_mask_q <= '0;
            tile_y_nb_q   <= '0;
            tile_z_nb_q   <= '0;
        end else begin
            state_q       <= state_d;
            lwe_k_q       <= lwe_k_d;
            blwe_k_q      <= blwe_k_d;
            level_q       <= level_d;
            cmd_rdy_q     <= cmd_rdy_d;
            tile_vld_q    <= tile_vld_d;
            done_q        <= done_d;
            tile_first_q  <= tile_first_d;
            tile_last_q   <= tile_last_d;
            tile_y_last_q <= tile_y_last_d;
            tile_x_mask_q <= tile_x_mask_d;
            tile_y_nb_q   <= tile_y_nb_d;
            tile_z_nb_q   <= tile_z_nb_d;
        end
    end

    assign cmd_rdy     = cmd_rdy_q;
    assign tile_vld    = tile_vld_q;
    assign done        = done_q;
    assign tile_first  = tile_first_q;
    assign tile_last   = tile_last_q;
    assign tile_y_last = tile_y_last_q;
    assign tile_x_mask = tile_x_mask_q;
    assign tile_y_nb   = tile_y_nb_q;
    assign tile_z_nb   = tile_z_nb_q;
endmodule

// File: tb/tb_pep_ks_tile_seq.sv
// Self-checking bench for pep_ks_tile_seq: directed table, random commands, reset and overlap sequences.
module tb_pep_ks_tile_seq;
    import pep_ks_common_definition_pkg::*;
    import pep_ks_tile_seq_pkg::*;

    localparam int YNB_W  = $clog2(LBY+1);
    localparam int ZNB_W  = $clog2(LBZ+1);
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    logic s_rst_n = 1'b0;
    logic cmd_vld = 1'b0;
    logic tile_rdy = 1'b0;
    logic [KS_LWE_K_W-1:0]  cmd_lwe_k = '0;
    logic [KS_BLWE_K_W-1:0] cmd_blwe_k = '0;
    logic [KS_LEVEL_W-1:0]  cmd_level = '0;
    logic cmd_rdy, tile_vld, tile_first, tile_last, tile_y_last, done;
    logic [KS_LWE_K_W-1:0]  tile_x;
    logic [KS_BLWE_K_W-1:0] tile_y;
    logic [KS_LEVEL_W-1:0]  tile_z;
    logic [LBX-1:0]         tile_x_mask;
    logic [YNB_W-1:0]       tile_y_nb;
    logic [ZNB_W-1:0]       tile_z_nb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pep_ks_tile_seq dut (
        .clk(clk), .s_rst_n(s_rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_lwe_k(cmd_lwe_k), .cmd_blwe_k(cmd_blwe_k), .cmd_level(cmd_level),
        .tile_vld(tile_vld), .tile_rdy(tile_rdy),
        .tile_x(tile_x), .tile_y(tile_y), .tile_z(tile_z),
        .tile_x_mask(tile_x_mask), .tile_y_nb(tile_y_nb), .tile_z_nb(tile_z_nb),
        .tile_first(tile_first), .tile_last(tile_last), .tile_y_last(tile_y_last),
        .done(done)
    );

    typedef struct {
        int lwe;
        int blwe;
        int lvl;
        int pct;
        int n;
        int mask;
        int ynb;
        int znb;
    } vec_t;

    task automatic check(input bit ok, input string name, input string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic tile_desc_t sample();
        tile_desc_t d;
        d.x = tile_x;  d.y = tile_y;  d.z = tile_z;
        d.x_mask = tile_x_mask;  d.y_nb = tile_y_nb;  d.z_nb = tile_z_nb;
        d.first = tile_first;  d.last = tile_last;  d.y_last = tile_y_last;
        return d;
    endfunction

    task automatic issue(input int lwe, input int blwe, input int lvl, output int waited);
        waited = 0;
        while (!cmd_rdy && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        check(cmd_rdy == 1'b1, "cmd_rdy_wait", $sformatf("got %0b want 1", cmd_rdy));
        cmd_lwe_k  = KS_LWE_K_W'(lwe);
        cmd_blwe_k = KS_BLWE_K_W'(blwe);
        cmd_level  = KS_LEVEL_W'(lvl);
        cmd_vld    = 1'b1;
    endtask

    // Follows one command from the acceptance edge; the model enumerates tiles by plain ceil-div arithmetic.
    task automatic track(input int lwe, input int blwe, input int lvl, input int pct,
                         input bit hold, input int abort_n,
                         output int ntiles, output tile_desc_t last_seen);
        tile_desc_t exp_q[$];
        tile_desc_t cur, held, d;
        bit stalled, seen_first, finished;
        int done_at, nx, ny, nz;
        nx = (lwe + LBX - 1) / LBX;
        ny = (blwe + LBY - 1) / LBY;
        nz = (lvl + LBZ - 1) / LBZ;
        if (nx > 0 && ny > 0 && nz > 0) begin
            for (int x = 0; x < nx; x++)
                for (int y = 0; y < ny; y++)
                    for (int z = 0; z < nz; z++) begin
                        d.x = KS_LWE_K_W'(x);
                        d.y = KS_BLWE_K_W'(y);
                        d.z = KS_LEVEL_W'(z);
                        if (x == nx - 1) d.x_mask = LBX'((1 << (lwe - (nx - 1) * LBX)) - 1);
                        else             d.x_mask = '1;
                        d.y_nb   = YNB_W'((y == ny - 1) ? blwe - (ny - 1) * LBY : LBY);
                        d.z_nb   = ZNB_W'((z == nz - 1) ? lvl - (nz - 1) * LBZ : LBZ);
                        d.first  = (x == 0 && y == 0 && z == 0);
                        d.last   = (x == nx - 1 && y == ny - 1 && z == nz - 1);
                        d.y_last = (y == ny - 1 && z == nz - 1);
                        exp_q.push_back(d);
                    end
        end
        ntiles = 0;
        last_seen = '0;
        held = '0;
        stalled = 1'b0;
        seen_first = 1'b0;
        finished = 1'b0;
        done_at = (exp_q.size() == 0) ? 2 : -1;
        for (int cyc = 1; cyc <= BUDGET && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (hold) begin
                    cmd_lwe_k = 3; cmd_blwe_k = 64; cmd_level = 3;
                end else begin
                    cmd_vld = 1'b0;
                end
            end
            check(cmd_rdy == 1'b0, "cmd_rdy_busy", $sformatf("cyc %0d got %0b want 0", cyc, cmd_rdy));
            if (cyc == done_at) begin
                check(done == 1'b1 && tile_vld == 1'b0, "done_pulse",
                      $sformatf("cyc %0d got done=%0b vld=%0b want done=1 vld=0", cyc, done, tile_vld));
                finished = 1'b1;
            end else begin
                check(done == 1'b0, "no_early_done", $sformatf("cyc %0d got %0b want 0", cyc, done));
                if (tile_vld) begin
                    cur = sample();
                    if (!seen_first) begin
                        seen_first = 1'b1;
                        check(cyc == 2, "first_latency", $sformatf("got %0d want 2", cyc));
                    end
                    if (stalled)
                        check(cur == held, "stall_hold", $sformatf("got %p want %p", cur, held));
                    if (exp_q.size() == 0) begin
                        check(1'b0, "extra_tile", $sformatf("got %p want none", cur));
                    end else begin
                        check(cur == exp_q[0], "tile_desc", $sformatf("got %p want %p", cur, exp_q[0]));
                    end
                    if ($urandom_range(99) < pct) begin
                        tile_rdy = 1'b1;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        ntiles++;
                        last_seen = cur;
                        stalled = 1'b0;
                        if (exp_q.size() == 0) done_at = cyc + 1;
                        if (ntiles == abort_n) return;
                    end else begin
                        tile_rdy = 1'b0;
                        stalled = 1'b1;
                        held = cur;
                    end
                end else begin
                    tile_rdy = 1'b0;
                    if (stalled)
                        check(1'b0, "vld_drop", $sformatf("cyc %0d got vld=0 want 1", cyc));
                    stalled = 1'b0;
                end
            end
        end
        if (!finished) check(1'b0, "cmd_timeout", $sformatf("got no done want done within %0d", BUDGET));
        tile_rdy = 1'b0;
    endtask

    vec_t vecs[7];
    int n, w;
    tile_desc_t ls;

    initial begin
        vecs[0] = '{lwe: 7, blwe: 130, lvl: 4, pct: 100, n: 18, mask: 1, ynb: 2,  znb: 1};
        vecs[1] = '{lwe: 3, blwe: 64,  lvl: 3, pct: 100, n: 1,  mask: 7, ynb: 64, znb: 3};
        vecs[2] = '{lwe: 0, blwe: 100, lvl: 2, pct: 100, n: 0,  mask: 0, ynb: 0,  znb: 0};
        vecs[3] = '{lwe: 7, blwe: 130, lvl: 4, pct: 50,  n: 18, mask: 1, ynb: 2,  znb: 1};
        vecs[4] = '{lwe: 5, blwe: 200, lvl: 7, pct: 70,  n: 24, mask: 3, ynb: 8,  znb: 1};
        vecs[5] = '{lwe: 4, blwe: 1,   lvl: 1, pct: 100, n: 2,  mask: 1, ynb: 1,  znb: 1};
        vecs[6] = '{lwe: 3, blwe: 0,   lvl: 3, pct: 100, n: 0,  mask: 0, ynb: 0,  znb: 0};

        repeat (2) @(negedge clk);
        check(tile_vld == 0 && done == 0 && tile_first == 0 && tile_last == 0, "reset_flags",
              $sformatf("got vld=%0b done=%0b first=%0b last=%0b want 0", tile_vld, done, tile_first, tile_last));
        check(tile_x == 0 && tile_y == 0 && tile_z == 0 && tile_x_mask == 0 && tile_y_nb == 0 && tile_z_nb == 0,
              "reset_fields", $sformatf("got %p want 0", sample()));
        s_rst_n = 1'b1;
        @(negedge clk);
        check(cmd_rdy == 1'b1, "rdy_after_reset", $sformatf("got %0b want 1", cmd_rdy));

        foreach (vecs[i]) begin
            issue(vecs[i].lwe, vecs[i].blwe, vecs[i].lvl, w);
            track(vecs[i].lwe, vecs[i].blwe, vecs[i].lvl, vecs[i].pct, 1'b0, -1, n, ls);
            check(n == vecs[i].n, "tile_count", $sformatf("vec %0d got %0d want %0d", i, n, vecs[i].n));
            if (vecs[i].n > 0) begin
                check(int'(ls.x_mask) == vecs[i].mask && int'(ls.y_nb) == vecs[i].ynb &&
                      int'(ls.z_nb) == vecs[i].znb && ls.last == 1'b1, "last_tile",
                      $sformatf("vec %0d got %p want mask=%0d ynb=%0d znb=%0d last=1",
                                i, ls, vecs[i].mask, vecs[i].ynb, vecs[i].znb));
            end
        end

        for (int r = 0; r < 6; r++) begin
            int lwe, blwe, lvl;
            lwe  = int'($urandom_range(10));
            blwe = int'($urandom_range(200));
            lvl  = int'($urandom_range(8));
            issue(lwe, blwe, lvl, w);
            track(lwe, blwe, lvl, 60, 1'b0, -1, n, ls);
        end

        // Reset in the middle of a command, then a clean command.
        issue(7, 130, 4, w);
        track(7, 130, 4, 100, 1'b0, 5, n, ls);
        check(n == 5, "abort_count", $sformatf("got %0d want 5", n));
        @(negedge clk);
        tile_rdy = 1'b0;
        s_rst_n = 1'b0;
        #1;
        check(tile_vld == 0 && done == 0 && tile_first == 0 && tile_last == 0 && tile_x == 0 &&
              tile_y == 0 && tile_z == 0 && tile_x_mask == 0, "async_clear",
              $sformatf("got vld=%0b done=%0b desc=%p want all 0", tile_vld, done, sample()));
        repeat (3) begin
            @(negedge clk);
            check(done == 0 && tile_vld == 0, "reset_hold",
                  $sformatf("got done=%0b vld=%0b want 0", done, tile_vld));
        end
        s_rst_n = 1'b1;
        @(negedge clk);
        check(cmd_rdy == 1 && done == 0 && tile_vld == 0, "post_reset",
              $sformatf("got rdy=%0b done=%0b vld=%0b want 1/0/0", cmd_rdy, done, tile_vld));
        issue(3, 64, 3, w);
        track(3, 64, 3, 100, 1'b0, -1, n, ls);
        check(n == 1 && ls.first && ls.last && ls.y_last, "post_reset_cmd",
              $sformatf("got n=%0d desc=%p want one first/last tile", n, ls));

        // cmd_vld held high through a command; the next one enters only after done.
        issue(7, 130, 4, w);
        track(7, 130, 4, 100, 1'b1, -1, n, ls);
        check(n == 18, "held_first_count", $sformatf("got %0d want 18", n));
        issue(3, 64, 3, w);
        check(w == 1, "accept_after_done", $sformatf("got wait %0d want 1", w));
        track(3, 64, 3, 100, 1'b0, -1, n, ls);
        check(n == 1 && int'(ls.x_mask) == 7 && int'(ls.y_nb) == 64 && int'(ls.z_nb) == 3, "held_second_cmd",
              $sformatf("got n=%0d desc=%p want 1 tile mask=7 ynb=64 znb=3", n, ls));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
